// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 3x3 active-low key matrix one column at a time. It synchronises
//   and debounces the row returns and reports each accepted press as a
//   row-major cell index 0..8 with a single-cycle key_valid pulse. The index
//   is held until the key is released.
//
// Parameters
//   SCAN_DIV      clocks per column dwell (>= 3, so that synchronised rows
//                 have settled before the dwell-end sample point)
//   DEBOUNCE_CNT  consecutive matching dwell-end samples needed to accept a
//                 press or a release (>= 1)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   row_n[2:0] row returns, active-low, asynchronous to clk (bit r = row r)
//   lock       high: presses are detected and tracked but never reported
//   col_n[2:0] column drive, active-low one-hot (bit c = column c)
//   key_index  debounced cell index 0..8, 4'hF when no key is reported
//   key_valid  one-cycle pulse when key_index becomes valid
//   key_busy   high from press acceptance until the release is accepted
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] row_n,
    input  logic       lock,
    output logic [2:0] col_n,
    output logic [3:0] key_index,
    output logic       key_valid,
    output logic       key_busy
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } stateT;

    stateT            state, stateNext;
    logic [2:0]       rowMeta, rowS;
    logic [DIV_W-1:0] dwellCnt;
    logic             tick;
    logic [CNT_W-1:0] dbCnt, dbNext, dbInc;
    logic [3:0]       candReg, candNext;
    logic [2:0]       patReg, patNext;
    logic [2:0]       colNext;
    logic [3:0]       keyIndexNext;
    logic             keyValidNext, keyBusyNext;
    logic [1:0]       colIdx, rowIdx;
    logic [3:0]       liveCand;
    logic             doAccept;
    logic [3:0]       acceptIdx;

    // Two-flop synchroniser on the asynchronous row returns.
    // NOTE: the synchroniser resets to the idle (all-high) pattern so that
    // leaving reset can never look like a key press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowMeta <= 3'b111;
            rowS    <= 3'b111;
        end else begin
            rowMeta <= row_n;
            rowS    <= rowMeta;
        end
    end

    // Free-running dwell counter; tick marks the sample point at dwell end.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwellCnt <= '0;
        end else if (tick) begin
            dwellCnt <= '0;
        end else begin
            dwellCnt <= dwellCnt + DIV_W'(1);
        end
    end

    assign tick  = (dwellCnt == DIV_LAST);
    assign dbInc = dbCnt + CNT_W'(1);

    // Index of the column currently driven low.
    always_comb begin
        case (col_n)
            3'b101:  colIdx = 2'd1;
            3'b011:  colIdx = 2'd2;
            default: colIdx = 2'd0;
        endcase
    end

    // Lowest-numbered low row wins when several rows are active.
    always_comb begin
        if (!rowS[0]) begin
            rowIdx = 2'd0;
        end else if (!rowS[1]) begin
            rowIdx = 2'd1;
        end else begin
            rowIdx = 2'd2;
        end
    end

    assign liveCand = 4'(rowIdx) * 4'd3 + 4'(colIdx);

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_n     <= 3'b110;
            dbCnt     <= '0;
            candReg   <= 4'hF;
            patReg    <= 3'b111;
            key_index <= 4'hF;
            key_valid <= 1'b0;
            key_busy  <= 1'b0;
        end else begin
            state     <= stateNext;
            col_n     <= colNext;
            dbCnt     <= dbNext;
            candReg   <= candNext;
            patReg    <= patNext;
            key_index <= keyIndexNext;
            key_valid <= keyValidNext;
            key_busy  <= keyBusyNext;
        end
    end

    // Next-state and output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        stateNext    = state;
        colNext      = col_n;
        dbNext       = dbCnt;
        candNext     = candReg;
        patNext      = patReg;
        keyIndexNext = key_index;
        keyValidNext = 1'b0;
        keyBusyNext  = key_busy;
        doAccept     = 1'b0;
        acceptIdx    = candReg;

        case (state)
            SCAN: begin
                if (tick) begin
                    if (rowS != 3'b111) begin
                        // Column stays put so the debounce keeps looking at
                        // the same key.
                        candNext = liveCand;
                        patNext  = rowS;
                        dbNext   = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            doAccept  = 1'b1;
                            acceptIdx = liveCand;
                        end else begin
                            stateNext = DEBOUNCE;
                        end
                    end else begin
                        colNext = {col_n[1:0], col_n[2]};
                    end
                end
            end

            DEBOUNCE: begin
                if (tick) begin
                    if (rowS == patReg) begin
                        if (dbInc == CNT_DONE) begin
                            doAccept  = 1'b1;
                            acceptIdx = candReg;
                        end else begin
                            dbNext = dbInc;
                        end
                    end else begin
                        // Bounce or a different pattern: start over, with
                        // rotation resuming from the current column.
                        dbNext    = '0;
                        stateNext = SCAN;
                    end
                end
            end

            PRESSED: begin
                // The column is frozen here, so other keys in other columns
                // are invisible; only all-rows-high counts toward release.
                if (tick) begin
                    if (rowS == 3'b111) begin
                        if (dbInc == CNT_DONE) begin
                            dbNext       = '0;
                            stateNext    = SCAN;
                            keyIndexNext = 4'hF;
                            keyBusyNext  = 1'b0;
                        end else begin
                            dbNext = dbInc;
                        end
                    end else begin
                        dbNext = '0;
                    end
                end
            end

            default: begin
                stateNext = SCAN;
                dbNext    = '0;
            end
        endcase

        // Acceptance: lock only gates the report, the press is still tracked
        // so that a held key cannot be reported after lock drops.
        if (doAccept) begin
            stateNext   = PRESSED;
            dbNext      = '0;
            keyBusyNext = 1'b1;
            if (!lock) begin
                keyIndexNext = acceptIdx;
                keyValidNext = 1'b1;
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives and reads the 3x3 game keypad matrix and produces the cell index stream consumed by the board-input logic (cell 0..8, row-major).
- Scans one column at a time, synchronises and debounces the row returns, and issues exactly one single-cycle key_valid pulse per debounced press.
- Holds the reported index until the key is released; a lock input suppresses new presses, for example after game over.

Parameters:
- SCAN_DIV, 16, clocks per column dwell. Must be >= 3 so synchronised rows settle before the sample point.
- DEBOUNCE_CNT, 4, consecutive matching dwell-end samples required to accept a press or a release. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- row_n  input  3  keypad row returns, active-low, asynchronous to clk; bit r = row r
- lock  input  1  high: presses are detected but never reported
- col_n  output  3  column drive, active-low one-hot; bit c = column c
- key_index  output  4  debounced cell index 0..8; 4'hF when no key is reported
- key_valid  output  1  one-cycle pulse when key_index becomes valid
- key_busy  output  1  high from press acceptance until release is accepted

Behaviour:
- Reset (asynchronous, immediate on rst high):
  - col_n=3'b110, key_index=4'hF, key_valid=0, key_busy=0.
  - state=SCAN; dwell and debounce counters cleared; both row synchroniser stages set to 3'b111.
  - Reset asserted mid-operation aborts any debounce or press with no key_valid pulse.
- Synchroniser: row_n passes through 2 flops giving row_s. All decisions use row_s only.
- Dwell counter: counts 0..SCAN_DIV-1 and wraps. tick = counter at SCAN_DIV-1. Samples are taken only on tick.
- Column rotation (SCAN state only, on tick with no press): 110 -> 101 -> 011 -> 110, wrapping. In all other states the column is frozen.
- Row priority: if several rows are low, the lowest-numbered row wins. Candidate index = 3*r + c.
- SCAN:
  - On tick, if row_s != 3'b111: latch the candidate index and the row pattern, set debounce count to 1, go to DEBOUNCE, keep the column.
  - If DEBOUNCE_CNT=1, go directly to accept.
- DEBOUNCE, on each tick:
  - Row pattern equal to the latched one: increment the count.
  - Pattern differs (including all-high): clear the count, return to SCAN, resume rotation from the current column.
  - Count reaches DEBOUNCE_CNT: accept the press.
- Accept:
  - lock=0: key_index = candidate and key_valid=1 for exactly one clk. key_busy rises in the same cycle as key_valid.
  - lock=1: no pulse, key_index stays 4'hF, key_busy=1.
  - Either way, go to PRESSED.
- PRESSED, on each tick:
  - row_s == 3'b111: increment the release count.
  - Otherwise: clear the release count.
  - Release count reaches DEBOUNCE_CNT: key_index=4'hF and key_busy=0 on the next clk, return to SCAN.
  - A second key pressed while one is held is ignored, with no new pulse. Changes in which row is low do not restart anything.
- lock:
  - Sampled only at accept.
  - Changing lock during PRESSED does not retroactively emit or cancel a pulse.
- key_index stays 4'hF in SCAN and DEBOUNCE. Values 9..14 never appear.
- Latency: from a bounce-free row change at the pins to key_valid is at most 2 + SCAN_DIV*(DEBOUNCE_CNT+3) clocks. Of this, up to 3 dwells wait for the column to come round, and DEBOUNCE_CNT dwells are debounce.
- key_valid is never asserted on two consecutive cycles. Between any two pulses, key_busy must fall.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset:
  - Action: assert rst with the keypad idle, then release it.
  - Required: col_n=110, key_index=F, key_valid=0.
  - Required: col_n cycles 110, 101, 011, 110 with a period of 4 clocks per column.
- Clean press:
  - Stimulus: hold cell 5 (row 1, col 2).
  - Required: exactly one key_valid pulse with key_index=5; key_busy=1 while held.
  - Required: after release, key_busy falls and key_index=F about 12 clocks later.
- Bounce rejection:
  - Stimulus: assert the cell 0 row for 2 dwells, drop it for 1 dwell, then hold steadily.
  - Required: no pulse during the bounce; a single pulse with key_index=0 after 3 stable dwells.
- Multi-key:
  - Stimulus: hold cells 4 and 7 in the same column simultaneously.
  - Required: key_index=4 (lowest row wins).
  - Stimulus: press cell 8 while cell 4 is held.
  - Required: no second pulse.
- Lock:
  - Stimulus: lock=1, press cell 3.
  - Required: key_busy=1, no key_valid, key_index=F.
  - Stimulus: lock=0 during hold, then release and re-press.
  - Required: one pulse with key_index=3.
- Reset mid-press:
  - Stimulus: assert rst during DEBOUNCE, and again during PRESSED.
  - Required: outputs return to reset values immediately, with no pulse.
  - Required: a continued hold after reset yields a fresh pulse once debounced.
